// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures pulse high time and decodes it to duty code 25..125 (period monitor under PWM_CAPTURE_PERIOD_EN).
// Latency: dc/dc_valid 25 cycles after the synchronized falling edge, constant for all widths.
// Backpressure: none; a falling edge while the divider is busy is dropped and flagged in sticky overrun.
module servo_pwm_capture #(
    parameter int FRECUENCIA = 1_000_000,
    parameter int PULSO_MIN  = 25_000,
    parameter int PULSO_MAX  = 125_000,
    parameter int TIMEOUT    = 2_000_000,
    parameter int PERIOD_TOL = 10_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pwm_in,
    output logic [7:0]  dc,
    output logic        dc_valid,
    output logic        busy,
    output logic        overrun,
    output logic        signal_lost,
    output logic [19:0] period_cycles,
    output logic        period_err
);

    localparam logic [19:0] P_MIN    = 20'(PULSO_MIN);
    localparam logic [19:0] P_MAX    = 20'(PULSO_MAX);
    localparam logic [16:0] RANGE    = 17'(PULSO_MAX - PULSO_MIN);
    localparam logic [20:0] LOST_LIM = 21'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_DIV} state_t;

    state_t      state, state_nx;
    logic        sync_q1, sync_q2, sync_d;
    logic        rise, fall, timeout_evt, start, div_done;
    logic [19:0] high_cnt;
    logic [20:0] lost_cnt;
    logic [19:0] w_c;
    logic [23:0] num_c;
    logic [23:0] div_num;
    logic [16:0] div_rem;
    logic [7:0]  div_q;
    logic [4:0]  div_cnt;
    logic [17:0] rem_sh;
    logic        rem_ge;
    logic [16:0] rem_nx;
    logic [7:0]  q_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_d  <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
            sync_d  <= sync_q2;
        end
    end

    assign rise        = sync_q2 & ~sync_d;
    assign fall        = ~sync_q2 & sync_d;
    assign timeout_evt = enable & ~rise & (lost_cnt == LOST_LIM);
    assign busy        = (state == S_DIV);
    assign start       = enable & (state == S_HIGH) & fall & ~timeout_evt;
    assign div_done    = enable & (state == S_DIV) & (div_cnt == 5'd23);

    always_comb begin
        w_c = high_cnt;
        if (high_cnt < P_MIN)
            w_c = P_MIN;
        else if (high_cnt > P_MAX)
            w_c = P_MAX;
        num_c = 24'(w_c - P_MIN) * 24'd100;
    end

    // One restoring-division step; the remainder always stays below RANGE.
    always_comb begin
        rem_sh = {div_rem, div_num[23]};
        rem_ge = (rem_sh >= {1'b0, RANGE});
        rem_nx = rem_ge ? 17'(rem_sh - {1'b0, RANGE}) : rem_sh[16:0];
        q_nx   = 8'({div_q, rem_ge});
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (rise) state_nx = S_HIGH;
                S_HIGH: begin
                    if (timeout_evt)
                        state_nx = S_IDLE;
                    else if (fall)
                        state_nx = S_DIV;
                end
                S_DIV:   if (div_cnt == 5'd23) state_nx = rise ? S_HIGH : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // The rise cycle itself is already high, so the count restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt <= '0;
            lost_cnt <= '0;
        end else if (!enable) begin
            high_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            if (rise)
                high_cnt <= 20'd1;
            else if (sync_q2 && high_cnt != '1)
                high_cnt <= high_cnt + 20'd1;
            if (rise)
                lost_cnt <= '0;
            else if (lost_cnt != '1)
                lost_cnt <= lost_cnt + 21'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_num <= '0;
            div_rem <= '0;
            div_q   <= '0;
            div_cnt <= '0;
        end else if (!enable) begin
            div_num <= '0;
            div_rem <= '0;
            div_q   <= '0;
            div_cnt <= '0;
        end else if (start) begin
            div_num <= num_c;
            div_rem <= '0;
            div_q   <= '0;
            div_cnt <= '0;
        end else if (state == S_DIV) begin
            div_num <= {div_num[22:0], 1'b0};
            div_rem <= rem_nx;
            div_q   <= q_nx;
            div_cnt <= div_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc          <= 8'd25;
            dc_valid    <= 1'b0;
            overrun     <= 1'b0;
            signal_lost <= 1'b0;
        end else begin
            dc_valid <= div_done;
            if (div_done)
                dc <= 8'd25 + q_nx;
            if (enable && state == S_DIV && fall)
                overrun <= 1'b1;
            if (timeout_evt)
                signal_lost <= 1'b1;
            else if (div_done)
                signal_lost <= 1'b0;
        end
    end

`ifdef PWM_CAPTURE_PERIOD_EN
    localparam logic [19:0] FREQ = 20'(FRECUENCIA);
    localparam logic [19:0] TOL  = 20'(PERIOD_TOL);

    logic [19:0] per_cnt;
    logic        per_armed;
    logic [19:0] per_diff;

    assign per_diff = (per_cnt >= FREQ) ? (per_cnt - FREQ) : (FREQ - per_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt       <= '0;
            per_armed     <= 1'b0;
            period_cycles <= '0;
            period_err    <= 1'b0;
        end else if (!enable) begin
            per_cnt   <= '0;
            per_armed <= 1'b0;
        end else if (rise) begin
            per_cnt   <= 20'd1;
            per_armed <= 1'b1;
            if (per_armed) begin
                period_cycles <= per_cnt;
                period_err    <= (per_diff > TOL);
            end
        end else begin
            if (timeout_evt)
                per_armed <= 1'b0;
            if (per_cnt != '1)
                per_cnt <= per_cnt + 20'd1;
        end
    end
`else
    assign period_cycles = '0;
    assign period_err    = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed bench for servo_pwm_capture with scaled timing (RANGE 1000 cycles, period 1000, timeout 3000).
module tb_servo_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pwm_in;
    logic [7:0]  dc;
    logic        dc_valid;
    logic        busy;
    logic        overrun;
    logic        signal_lost;
    logic [19:0] period_cycles;
    logic        period_err;

    servo_pwm_capture #(
        .FRECUENCIA(1000),
        .PULSO_MIN (250),
        .PULSO_MAX (1250),
        .TIMEOUT   (3000),
        .PERIOD_TOL(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .dc           (dc),
        .dc_valid     (dc_valid),
        .busy         (busy),
        .overrun      (overrun),
        .signal_lost  (signal_lost),
        .period_cycles(period_cycles),
        .period_err   (period_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int width;
        int low;
        int exp_dc;
        int exp_per;
        int exp_err;
    } vec_t;

    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   got_lat;
    int   got_dc;
    int   n_valid;
    logic sl_before;
    logic sl_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Watch n cycles (called at posedge+1); record first dc_valid position and values.
    task automatic watch(input int n);
        logic prev_sl;
        prev_sl = signal_lost;
        got_lat = -1;
        got_dc  = -1;
        n_valid = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (dc_valid) begin
                n_valid++;
                if (got_lat < 0) begin
                    got_lat   = k;
                    got_dc    = int'(dc);
                    sl_at     = signal_lost;
                    sl_before = prev_sl;
                end
            end
            prev_sl = signal_lost;
        end
    endtask

    // Exactly width high cycles then low cycles, so rise-to-rise period = width + low.
    task automatic pulse(input int width, input int low);
        pwm_in = 1'b1;
        repeat (width) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        watch(low);
    endtask

    initial begin
        int lat1;
        int dc1;
        int nv1;
        int ep;
        int ee;

        vecs[0] = '{250,  750, 25,  0,    0};
        vecs[1] = '{750,  250, 75,  1000, 0};
        vecs[2] = '{759,  241, 75,  1000, 0};
        vecs[3] = '{1250, 300, 125, 1000, 0};
        vecs[4] = '{100,  900, 25,  1550, 1};
        vecs[5] = '{2000, 300, 125, 1000, 0};
        vecs[6] = '{250,  770, 25,  2300, 1};
        vecs[7] = '{250,  740, 25,  1020, 1};
        vecs[8] = '{250,  760, 25,  990,  0};
        vecs[9] = '{500,  500, 50,  1010, 0};

        rst    = 1'b1;
        enable = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dc", dc, 25);
        check("rst_dc_valid", dc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_signal_lost", signal_lost, 0);
        check("rst_period", period_cycles, 0);
        check("rst_period_err", period_err, 0);
        repeat (4) @(posedge clk);
        #1;

        // Fall-to-dc_valid is 27 edges from driving low: 2 sync stages + 25.
        for (int i = 0; i < 10; i++) begin
            pulse(vecs[i].width, vecs[i].low);
`ifdef PWM_CAPTURE_PERIOD_EN
            ep = vecs[i].exp_per;
            ee = vecs[i].exp_err;
`else
            ep = 0;
            ee = 0;
`endif
            check($sformatf("v%0d_latency", i), got_lat, 27);
            check($sformatf("v%0d_dc", i), got_dc, vecs[i].exp_dc);
            check($sformatf("v%0d_valid_count", i), n_valid, 1);
            check($sformatf("v%0d_period", i), period_cycles, ep);
            check($sformatf("v%0d_period_err", i), period_err, ee);
        end

        // New rise lands exactly in the dc_valid cycle of the previous pulse.
        pwm_in = 1'b1;
        repeat (750) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        lat1 = -1;
        dc1  = -1;
        nv1  = 0;
        for (int k = 1; k <= 1275; k++) begin
            @(posedge clk);
            #1;
            if (dc_valid) begin
                nv1++;
                if (lat1 < 0) begin
                    lat1 = k;
                    dc1  = int'(dc);
                end
            end
            if (k == 25)
                pwm_in = 1'b1;
        end
        pwm_in = 1'b0;
        watch(60);
        check("coinc_first_latency", lat1, 27);
        check("coinc_first_dc", dc1, 75);
        check("coinc_first_count", nv1, 1);
        check("coinc_second_latency", got_lat, 27);
        check("coinc_second_dc", got_dc, 125);

        // Disable in the middle of a high phase: nothing decoded, dc holds.
        pwm_in = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        watch(60);
        check("disable_valid_count", n_valid, 0);
        check("disable_dc_hold", dc, 125);
        check("disable_busy", busy, 0);
        enable = 1'b1;
        watch(20);
        check("disable_no_lost", signal_lost, 0);

        // Line stuck low past the timeout, then recovery on the next good pulse.
        repeat (3100) @(posedge clk);
        #1;
        check("timeout_lost", signal_lost, 1);
        pulse(500, 500);
        check("recover_latency", got_lat, 27);
        check("recover_dc", got_dc, 50);
        check("recover_lost_before", sl_before, 1);
        check("recover_lost_cleared", sl_at, 0);

        // Reset ten cycles into a division.
        pwm_in = 1'b1;
        repeat (1250) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_div_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        watch(40);
        check("rst_div_valid_count", n_valid, 0);
        check("rst_div_dc", dc, 25);
        check("rst_div_busy", busy, 0);
        check("rst_div_overrun", overrun, 0);

        // Second falling edge while the divider is running.
        pwm_in = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        watch(60);
        check("ovr_latency", got_lat, 17);
        check("ovr_dc", got_dc, 30);
        check("ovr_valid_count", n_valid, 1);
        check("ovr_sticky", overrun, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
